// File: rtl/port_bus_pkg.sv
// Shared definitions for the output port bank write path: address window,
// arbiter state encoding and the port address range check.
package port_bus_pkg;

    localparam int         IDX_W          = 3;
    localparam logic [7:0] PORT_BASE_DEF  = 8'hE0;
    localparam int         PORT_COUNT_DEF = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    // Compared in 9 bits so a window touching 0xFF cannot wrap back to 0x00.
    function automatic logic in_port_range(input logic [7:0] addr,
                                           input logic [7:0] base  = PORT_BASE_DEF,
                                           input int         count = PORT_COUNT_DEF);
        logic [8:0] lo;
        logic [8:0] hi;
        lo = {1'b0, base};
        hi = lo + 9'(count) - 9'd1;
        return ({1'b0, addr} >= lo) && ({1'b0, addr} <= hi);
    endfunction

endpackage

// File: rtl/port_write_arbiter_if.sv
// Requester-side and port-bank-side signals of the shared port write path.
interface port_write_arbiter_if
    import port_bus_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_lock;
    logic [8*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   req_err;
    logic                 wr_en;
    logic [7:0]           wr_addr;
    logic [7:0]           wr_data;
    logic [IDX_W-1:0]     grant_id;
    logic                 locked;

    modport master (
        output req_valid, req_lock, req_addr, req_data,
        input  req_ready, req_err, wr_en, wr_addr, wr_data, grant_id, locked
    );

    modport slave (
        input  req_valid, req_lock, req_addr, req_data,
        output req_ready, req_err, wr_en, wr_addr, wr_data, grant_id, locked
    );
endinterface

// File: rtl/port_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping to the lowest set request otherwise.
module rr_pick
    import port_bus_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_o && req_i[i] && (i >= int'(ptr_i))) begin
                any_o      = 1'b1;
                idx_o      = IDX_W'(i);
                grant_o[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_o && req_i[i]) begin
                any_o      = 1'b1;
                idx_o      = IDX_W'(i);
                grant_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/port_write_arbiter.sv
// Round-robin write arbiter for the output port bank with optional locked
// bursts, idle-timeout lock release and out-of-range rejection.
module port_write_arbiter
    import port_bus_pkg::*;
#(
    parameter int         NUM_REQ      = 4,
    parameter logic [7:0] PORT_BASE    = PORT_BASE_DEF,
    parameter int         PORT_COUNT   = PORT_COUNT_DEF,
    parameter int         LOCK_TIMEOUT = 15
) (
    input logic                clk,
    input logic                reset,
    port_write_arbiter_if.slave bus
);

    arb_state_e          state_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [IDX_W-1:0]    owner_q;
    logic [7:0]          idle_cnt_q;
    logic [7:0]          idle_cnt_d;
    logic                wr_en_q;
    logic [7:0]          wr_addr_q;
    logic [7:0]          wr_data_q;
    logic [NUM_REQ-1:0]  req_err_q;
    logic [IDX_W-1:0]    grant_id_q;

    logic [NUM_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic [NUM_REQ-1:0]  owner_oh;
    logic [NUM_REQ-1:0]  req_ready;
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W-1:0]    ptr_next;
    logic [7:0]          sel_addr;
    logic [7:0]          sel_data;
    logic                sel_lock;
    logic                sel_in_range;
    logic                xfer;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i   (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_comb begin
        owner_oh = '0;
        sel_addr = '0;
        sel_data = '0;
        sel_lock = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_oh[i] = (owner_q == IDX_W'(i));
        end
        sel_idx   = (state_q == ST_LOCK) ? owner_q : pick_idx;
        req_ready = (state_q == ST_LOCK) ? owner_oh : pick_grant;
        xfer      = (state_q == ST_LOCK) ? |(bus.req_valid & owner_oh) : pick_any;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_addr = bus.req_addr[8*i +: 8];
                sel_data = bus.req_data[8*i +: 8];
                sel_lock = bus.req_lock[i];
            end
        end
        ptr_next     = (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
        idle_cnt_d   = idle_cnt_q + 8'd1;
        sel_in_range = in_port_range(sel_addr, PORT_BASE, PORT_COUNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            idle_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            req_err_q  <= '0;
            grant_id_q <= '0;
        end else begin
            wr_en_q   <= xfer && sel_in_range;
            req_err_q <= (xfer && !sel_in_range) ? req_ready : '0;
            if (xfer && sel_in_range) begin
                wr_addr_q <= sel_addr;
                wr_data_q <= sel_data;
            end
            if (xfer) begin
                grant_id_q <= sel_idx;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        rr_ptr_q <= ptr_next;
                        if (sel_lock) begin
                            state_q    <= ST_LOCK;
                            owner_q    <= sel_idx;
                            idle_cnt_q <= '0;
                        end
                    end
                end
                ST_LOCK: begin
                    if (xfer) begin
                        if (sel_lock) begin
                            idle_cnt_q <= '0;
                        end else begin
                            state_q  <= ST_IDLE;
                            rr_ptr_q <= ptr_next;
                        end
                    end else if (idle_cnt_d == 8'(LOCK_TIMEOUT)) begin
                        // Release cycle carries no transfer; arbitration resumes next cycle.
                        state_q    <= ST_IDLE;
                        rr_ptr_q   <= ptr_next;
                        idle_cnt_q <= '0;
                    end else begin
                        idle_cnt_q <= idle_cnt_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.req_err   = req_err_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.locked    = (state_q == ST_LOCK);

endmodule

// File: tb/tb_port_write_arbiter.sv
// Bench for port_write_arbiter: directed scenarios plus randomized requesters
// checked cycle by cycle against a behavioural model of the arbitration rules.
module tb_port_write_arbiter;

    localparam int N  = 4;
    localparam int TO = 15;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    port_write_arbiter_if #(.NUM_REQ(N)) bus ();

    port_write_arbiter #(
        .NUM_REQ      (N),
        .PORT_BASE    (8'hE0),
        .PORT_COUNT   (16),
        .LOCK_TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [N-1:0] v;
    logic [N-1:0] lk;
    logic [7:0]   a [N];
    logic [7:0]   d [N];

    assign bus.req_valid = v;
    assign bus.req_lock  = lk;
    assign bus.req_addr  = {a[3], a[2], a[1], a[0]};
    assign bus.req_data  = {d[3], d[2], d[1], d[0]};

    int checks = 0;
    int errors = 0;

    // model state
    bit           m_locked;
    int           m_owner;
    int           m_ptr;
    int           m_idle;
    logic         e_wr_en;
    logic [7:0]   e_addr;
    logic [7:0]   e_data;
    logic [N-1:0] e_err;
    int           e_gid;
    logic [N-1:0] xfer_mask;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_ptr    = 0;
        m_idle   = 0;
        e_wr_en  = 1'b0;
        e_addr   = 8'h00;
        e_data   = 8'h00;
        e_err    = '0;
        e_gid    = 0;
    endtask

    function automatic logic [N-1:0] model_ready();
        if (m_locked) return N'(1 << m_owner);
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return N'(1 << ((m_ptr + k) % N));
        end
        return '0;
    endfunction

    task automatic step(input logic rst);
        logic [N-1:0] rdy;
        int           idx;
        reset = rst;
        #1;
        rdy = model_ready();
        if (!rst) chk("ready", 32'(bus.req_ready), 32'(rdy));
        xfer_mask = rdy & v;
        idx = 0;
        for (int i = 0; i < N; i++) if (rdy[i]) idx = i;
        @(posedge clk);
        if (rst) begin
            model_reset();
            xfer_mask = '0;
        end else begin
            e_wr_en = 1'b0;
            e_err   = '0;
            if (xfer_mask != 0) begin
                e_gid = idx;
                if (int'(a[idx]) >= 224 && int'(a[idx]) <= 239) begin
                    e_wr_en = 1'b1;
                    e_addr  = a[idx];
                    e_data  = d[idx];
                end else begin
                    e_err = N'(1 << idx);
                end
                if (!m_locked) begin
                    m_ptr = (idx + 1) % N;
                    if (lk[idx]) begin
                        m_locked = 1'b1;
                        m_owner  = idx;
                        m_idle   = 0;
                    end
                end else if (lk[idx]) begin
                    m_idle = 0;
                end else begin
                    m_locked = 1'b0;
                    m_ptr    = (m_owner + 1) % N;
                end
            end else if (m_locked) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_locked = 1'b0;
                    m_ptr    = (m_owner + 1) % N;
                    m_idle   = 0;
                end
            end
        end
        #1;
        chk("wr_en",    32'(bus.wr_en),    32'(e_wr_en));
        chk("wr_addr",  32'(bus.wr_addr),  32'(e_addr));
        chk("wr_data",  32'(bus.wr_data),  32'(e_data));
        chk("req_err",  32'(bus.req_err),  32'(e_err));
        chk("grant_id", 32'(bus.grant_id), 32'(e_gid));
        chk("locked",   32'(bus.locked),   32'(m_locked));
    endtask

    function automatic logic [7:0] pick_addr();
        case ($urandom_range(6))
            0:       return 8'hDF;
            1:       return 8'hE0;
            2:       return 8'hEF;
            3:       return 8'hF0;
            4:       return 8'($urandom);
            default: return 8'(8'hE0 + 8'($urandom_range(15)));
        endcase
    endfunction

    task automatic randomize_reqs(input int pct);
        for (int i = 0; i < N; i++) begin
            if (xfer_mask[i] || !v[i]) begin
                if (int'($urandom_range(99)) < pct) begin
                    v[i]  = 1'b1;
                    a[i]  = pick_addr();
                    d[i]  = 8'($urandom);
                    lk[i] = ($urandom_range(3) == 0);
                end else begin
                    v[i]  = 1'b0;
                    lk[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic idle_reset();
        v  = '0;
        lk = '0;
        step(1'b1);
    endtask

    initial begin
        int cnt;
        v  = '0;
        lk = '0;
        for (int i = 0; i < N; i++) begin
            a[i] = 8'h00;
            d[i] = 8'h00;
        end
        model_reset();
        step(1'b1);
        step(1'b1);
        chk("rst_wr_en",  32'(bus.wr_en),  32'd0);
        chk("rst_locked", 32'(bus.locked), 32'd0);

        // single request
        v = 4'b0001; a[0] = 8'hE3; d[0] = 8'h5A;
        step(1'b0);
        chk("single_wen",  32'(bus.wr_en),    32'd1);
        chk("single_addr", 32'(bus.wr_addr),  32'hE3);
        chk("single_data", 32'(bus.wr_data),  32'h5A);
        chk("single_gid",  32'(bus.grant_id), 32'd0);
        v = '0;
        step(1'b0);

        // fairness from reset
        idle_reset();
        v = 4'b1111;
        for (int i = 0; i < N; i++) begin
            a[i] = 8'(8'hE0 + i);
            d[i] = 8'(8'h10 + i);
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b0);
            chk("fair_gid", 32'(bus.grant_id), 32'(k % N));
            chk("fair_wen", 32'(bus.wr_en),    32'd1);
        end
        v = '0;
        step(1'b0);

        // lock burst from req 2
        idle_reset();
        v = 4'b0010; a[1] = 8'hE1;
        step(1'b0);
        v = 4'b0111; lk = 4'b0100; a[2] = 8'hE2; a[0] = 8'hE0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) lk = 4'b0000;
            step(1'b0);
            chk("burst_gid", 32'(bus.grant_id), 32'd2);
        end
        chk("burst_unlock", 32'(bus.locked), 32'd0);
        v = 4'b0011;
        step(1'b0);
        chk("burst_next", 32'(bus.grant_id), 32'd0);
        v = '0;
        step(1'b0);

        // lock timeout
        idle_reset();
        v = 4'b0010; lk = 4'b0010; a[1] = 8'hE5;
        step(1'b0);
        v = 4'b0001; lk = 4'b0000; a[0] = 8'hE6;
        cnt = 0;
        while (bus.locked && cnt < 40) begin
            cnt++;
            step(1'b0);
        end
        chk("timeout_len", 32'(cnt), 32'(TO));
        step(1'b0);
        chk("timeout_gid", 32'(bus.grant_id), 32'd0);
        chk("timeout_wen", 32'(bus.wr_en),    32'd1);
        v = '0;
        step(1'b0);

        // range errors
        idle_reset();
        v = 4'b0001; a[0] = 8'hE3; d[0] = 8'h11;
        step(1'b0);
        v = 4'b1000; a[3] = 8'hF0; d[3] = 8'h22;
        step(1'b0);
        chk("rng_hi_wen",  32'(bus.wr_en),   32'd0);
        chk("rng_hi_err",  32'(bus.req_err), 32'h8);
        chk("rng_hi_addr", 32'(bus.wr_addr), 32'hE3);
        v = '0;
        step(1'b0);
        chk("rng_err_clr", 32'(bus.req_err), 32'h0);
        v = 4'b1000; a[3] = 8'hDF;
        step(1'b0);
        chk("rng_lo_err",  32'(bus.req_err), 32'h8);
        chk("rng_lo_addr", 32'(bus.wr_addr), 32'hE3);
        v = '0;
        step(1'b0);

        // reset mid-lock
        idle_reset();
        v = 4'b0010; lk = 4'b0010; a[1] = 8'hE7;
        step(1'b0);
        chk("ml_locked", 32'(bus.locked), 32'd1);
        step(1'b1);
        chk("ml_wen",    32'(bus.wr_en),   32'd0);
        chk("ml_locked0",32'(bus.locked),  32'd0);
        chk("ml_err",    32'(bus.req_err), 32'd0);
        v = 4'b1111; lk = 4'b0000;
        for (int i = 0; i < N; i++) a[i] = 8'(8'hE8 + i);
        step(1'b0);
        chk("ml_next", 32'(bus.grant_id), 32'd0);

        // randomized traffic at several loads
        idle_reset();
        for (int k = 0; k < 2000; k++) begin
            randomize_reqs(70);
            step(1'b0);
        end
        for (int k = 0; k < 1500; k++) begin
            randomize_reqs(25);
            step(1'b0);
        end
        for (int k = 0; k < 1500; k++) begin
            randomize_reqs(8);
            step(1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
